npu_act_mem_arbiter: RTL and testbench

Arbitrates the single port of the NPU activation memory between three requesters: the post-MAC max-pool/ReLU writer (hardware results), the host image loader (writes), and the MAC operand fetch (reads). Owns the memory enable/write-enable/address/data pins, returns one-cycle acknowledges to each requester, and re-times read data back to the fetch unit. Host writes are fenced off while an NPU layer is running, and out-of-range writes are dropped and flagged.

---
 rtl/npu_act_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_npu_act_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_act_mem_arbiter.sv
// Single-port activation memory arbiter: read fetch, hardware writer and host loader.
// Define NPU_ACT_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed read > hw > host.
module npu_act_mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned ACT_DEPTH  = 3872,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            npu_layer_in_progress,
  input  logic                  hw_mem_wr,
  input  logic [ADDR_WIDTH-1:0] hw_mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] hw_mem_wr_data,
  output logic                  hw_mem_wr_ack_p,
  input  logic                  host_mem_wr,
  input  logic [ADDR_WIDTH-1:0] host_mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_mem_wr_data,
  output logic                  host_mem_wr_ack_p,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack_p,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid_p,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  addr_err
);

  localparam int unsigned SRC_W = 2;
  localparam int unsigned CNT_W = 2;
  localparam logic [SRC_W-1:0] SRC_RD   = SRC_W'(0);
  localparam logic [SRC_W-1:0] SRC_HW   = SRC_W'(1);
  localparam logic [SRC_W-1:0] SRC_HOST = SRC_W'(2);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

  state_t                 state;
  logic                   is_rd;
  logic [CNT_W-1:0]       rd_cnt;
  logic [2:0]             req;
  logic                   win_vld;
  logic [SRC_W-1:0]       win;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]  win_data;
  logic                   win_oor;

`ifdef NPU_ACT_ARB_ROUND_ROBIN_EN
  logic [SRC_W-1:0]       rr_ptr;

  // rr_ptr names the requester with highest priority this round
  function automatic logic [SRC_W-1:0] rr_pick(input logic [2:0] r, input logic [SRC_W-1:0] p);
    logic [SRC_W-1:0] a, b, c;
    a = p;
    b = (a == SRC_HOST) ? SRC_RD : a + SRC_W'(1);
    c = (b == SRC_HOST) ? SRC_RD : b + SRC_W'(1);
    if (r[a])      return a;
    else if (r[b]) return b;
    else           return c;
  endfunction
`endif

  // Host writes are fenced while any layer is running
  assign req     = {host_mem_wr & (npu_layer_in_progress == 3'd0), hw_mem_wr, rd_req};
  assign win_vld = |req;

  always_comb begin
    win      = SRC_RD;
    win_addr = rd_addr;
    win_data = '0;
`ifdef NPU_ACT_ARB_ROUND_ROBIN_EN
    win = rr_pick(req, rr_ptr);
`else
    if (req[0])      win = SRC_RD;
    else if (req[1]) win = SRC_HW;
    else             win = SRC_HOST;
`endif
    if (win == SRC_HW) begin
      win_addr = hw_mem_wr_addr;
      win_data = hw_mem_wr_data;
    end else if (win == SRC_HOST) begin
      win_addr = host_mem_wr_addr;
      win_data = host_mem_wr_data;
    end
    win_oor = (win != SRC_RD) && (32'(win_addr) >= ACT_DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      is_rd             <= 1'b0;
      rd_cnt            <= '0;
      hw_mem_wr_ack_p   <= 1'b0;
      host_mem_wr_ack_p <= 1'b0;
      rd_ack_p          <= 1'b0;
      rd_data_valid_p   <= 1'b0;
      rd_data           <= '0;
      mem_en            <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      addr_err          <= 1'b0;
`ifdef NPU_ACT_ARB_ROUND_ROBIN_EN
      rr_ptr            <= SRC_RD;
`endif
    end else begin
      hw_mem_wr_ack_p   <= 1'b0;
      host_mem_wr_ack_p <= 1'b0;
      rd_ack_p          <= 1'b0;
      rd_data_valid_p   <= 1'b0;
      mem_en            <= 1'b0;
      mem_we            <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_vld) begin
            state             <= ISSUE;
            is_rd             <= (win == SRC_RD);
            mem_addr          <= win_addr;
            mem_wdata         <= win_data;
            mem_en            <= !win_oor;
            mem_we            <= (win != SRC_RD) && !win_oor;
            addr_err          <= addr_err | win_oor;
            rd_ack_p          <= (win == SRC_RD);
            hw_mem_wr_ack_p   <= (win == SRC_HW);
            host_mem_wr_ack_p <= (win == SRC_HOST);
`ifdef NPU_ACT_ARB_ROUND_ROBIN_EN
            rr_ptr            <= (win == SRC_HOST) ? SRC_RD : win + SRC_W'(1);
`endif
          end
        end
        ISSUE: begin
          if (is_rd) begin
            state  <= RD_WAIT;
            rd_cnt <= CNT_W'(1);
          end else begin
            state  <= IDLE;
          end
        end
        RD_WAIT: begin
          // Sample memory output exactly RD_LATENCY cycles after the issue cycle
          if (rd_cnt == CNT_W'(RD_LATENCY)) begin
            rd_data         <= mem_rdata;
            rd_data_valid_p <= 1'b1;
            state           <= IDLE;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_act_mem_arbiter.sv
// Self-checking bench for npu_act_mem_arbiter with a behavioural memory and a read-data scoreboard.
module tb_npu_act_mem_arbiter;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 12;
  localparam int unsigned RDL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    npu_layer_in_progress = '0;
  logic          hw_mem_wr = 1'b0;
  logic [AW-1:0] hw_mem_wr_addr = '0;
  logic [DW-1:0] hw_mem_wr_data = '0;
  logic          hw_mem_wr_ack_p;
  logic          host_mem_wr = 1'b0;
  logic [AW-1:0] host_mem_wr_addr = '0;
  logic [DW-1:0] host_mem_wr_data = '0;
  logic          host_mem_wr_ack_p;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ack_p;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid_p;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          addr_err;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_mem [4096] = '{default: '0};

  logic [DW-1:0] mem [4096] = '{default: '0};
  logic [DW-1:0] rpipe [RDL];

  wire [7+AW+2*DW-1:0] all_outs = {hw_mem_wr_ack_p, host_mem_wr_ack_p, rd_ack_p, rd_data_valid_p,
                                   mem_en, mem_we, addr_err, mem_addr, mem_wdata, rd_data};

  npu_act_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACT_DEPTH(3872), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst(rst), .npu_layer_in_progress(npu_layer_in_progress),
    .hw_mem_wr(hw_mem_wr), .hw_mem_wr_addr(hw_mem_wr_addr), .hw_mem_wr_data(hw_mem_wr_data),
    .hw_mem_wr_ack_p(hw_mem_wr_ack_p),
    .host_mem_wr(host_mem_wr), .host_mem_wr_addr(host_mem_wr_addr), .host_mem_wr_data(host_mem_wr_data),
    .host_mem_wr_ack_p(host_mem_wr_ack_p),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack_p(rd_ack_p), .rd_data(rd_data),
    .rd_data_valid_p(rd_data_valid_p),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Synchronous memory with RDL-cycle read pipeline; non-read cycles inject a poison value
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    rpipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 16'hBAD0;
    for (int i = 1; i < int'(RDL); i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RDL-1];

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_hw_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] layer);
    npu_layer_in_progress = layer;
    hw_mem_wr = 1'b1; hw_mem_wr_addr = a; hw_mem_wr_data = d;
    exp_mem[a] = d;
    @(negedge clk);
    checks++;
    if ({hw_mem_wr_ack_p, mem_en, mem_we, mem_addr, mem_wdata, addr_err} !== {3'b111, a, d, 1'b0}) begin
      errors++;
      $display("FAIL hw_write_issue: ack/en/we/addr/data/err got %b%b%b %h %h %b expected 111 %h %h 0",
               hw_mem_wr_ack_p, mem_en, mem_we, mem_addr, mem_wdata, addr_err, a, d);
    end
    hw_mem_wr = 1'b0;
    @(negedge clk);
    checks++;
    if ({hw_mem_wr_ack_p, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL hw_write_one_cycle: ack/en got %b%b expected 00", hw_mem_wr_ack_p, mem_en);
    end
  endtask

  task automatic test_read(input logic [AW-1:0] a);
    int n;
    logic [DW-1:0] e;
    rd_req = 1'b1; rd_addr = a;
    exp_q.push_back(exp_mem[a]);
    @(negedge clk);
    checks++;
    if ({rd_ack_p, mem_en, mem_we, mem_addr} !== {3'b110, a}) begin
      errors++;
      $display("FAIL read_issue: ack/en/we/addr got %b%b%b %h expected 110 %h",
               rd_ack_p, mem_en, mem_we, mem_addr, a);
    end
    rd_req = 1'b0;
    n = 0;
    while (n < 12 && !rd_data_valid_p) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    checks++;
    if (n !== 1 + int'(RDL)) begin
      errors++;
      $display("FAIL read_latency: valid after %0d cycles expected %0d", n, 1 + RDL);
    end
    checks++;
    if (rd_data !== e) begin
      errors++;
      $display("FAIL read_data addr %h: got %h expected %h", a, rd_data, e);
    end
    @(negedge clk);
    checks++;
    if ({rd_data_valid_p, rd_data} !== {1'b0, e}) begin
      errors++;
      $display("FAIL read_hold: valid/data got %b %h expected 0 %h", rd_data_valid_p, rd_data, e);
    end
  endtask

  task automatic test_host_fence;
    logic leaked;
    int n;
    npu_layer_in_progress = 3'd3;
    host_mem_wr = 1'b1; host_mem_wr_addr = 12'h020; host_mem_wr_data = 16'h5555;
    leaked = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (host_mem_wr_ack_p || mem_en) leaked = 1'b1;
    end
    checks++;
    if (leaked !== 1'b0) begin
      errors++;
      $display("FAIL host_fenced: ack seen while layer running got %b expected 0", leaked);
    end
    npu_layer_in_progress = 3'd0;
    exp_mem[12'h020] = 16'h5555;
    n = 0;
    while (n < 2 && !host_mem_wr_ack_p) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({host_mem_wr_ack_p, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'h020, 16'h5555}) begin
      errors++;
      $display("FAIL host_release: ack/we/addr/data got %b%b %h %h expected 11 020 5555",
               host_mem_wr_ack_p, mem_we, mem_addr, mem_wdata);
    end
    host_mem_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_out_of_range;
    hw_mem_wr = 1'b1; hw_mem_wr_addr = 12'hF20; hw_mem_wr_data = 16'h7777;
    @(negedge clk);
    checks++;
    if ({hw_mem_wr_ack_p, mem_en, mem_we, addr_err} !== 4'b1001) begin
      errors++;
      $display("FAIL oor_write: ack/en/we/err got %b%b%b%b expected 1001",
               hw_mem_wr_ack_p, mem_en, mem_we, addr_err);
    end
    hw_mem_wr = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (addr_err !== 1'b1) begin
      errors++;
      $display("FAIL oor_sticky: addr_err got %b expected 1", addr_err);
    end
  endtask

  task automatic test_reset_mid_read;
    logic seen;
    rd_req = 1'b1; rd_addr = 12'h010;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_mid_read: outputs got %h expected 0", all_outs);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rd_data_valid_p) seen = 1'b1;
    end
    checks++;
    if ({seen, addr_err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_abort: stray_valid/addr_err got %b%b expected 00", seen, addr_err);
    end
  endtask

  task automatic test_arbitration;
    int grants[$];
    int exp_seq[6];
    logic [DW-1:0] e;
`ifdef NPU_ACT_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 2, 0, 1, 2};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
    npu_layer_in_progress = 3'd0;
    rd_req = 1'b1;      rd_addr = 12'h010;
    hw_mem_wr = 1'b1;   hw_mem_wr_addr = 12'h100;   hw_mem_wr_data = 16'h1111;
    host_mem_wr = 1'b1; host_mem_wr_addr = 12'h200; host_mem_wr_data = 16'h2222;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (c >= 80 || grants.size() >= 6) begin
        rd_req = 1'b0; hw_mem_wr = 1'b0; host_mem_wr = 1'b0;
      end
      if (int'(rd_ack_p) + int'(hw_mem_wr_ack_p) + int'(host_mem_wr_ack_p) > 1) begin
        checks++; errors++;
        $display("FAIL arb_onehot: acks got %b%b%b", rd_ack_p, hw_mem_wr_ack_p, host_mem_wr_ack_p);
      end
      if (rd_ack_p)          begin grants.push_back(0); exp_q.push_back(exp_mem[12'h010]); end
      if (hw_mem_wr_ack_p)   begin grants.push_back(1); exp_mem[12'h100] = 16'h1111; end
      if (host_mem_wr_ack_p) begin grants.push_back(2); exp_mem[12'h200] = 16'h2222; end
      if (rd_data_valid_p) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL arb_read_data: unexpected valid data %h expected none", rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL arb_read_data: got %h expected %h", rd_data, e);
          end
        end
      end
    end
    checks++;
    if (grants.size() < 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL arb_grant_count: grants %0d pending reads %0d expected >=6 and 0",
               grants.size(), exp_q.size());
    end
    for (int i = 0; i < 6 && i < grants.size(); i++) begin
      checks++;
      if (grants[i] !== exp_seq[i]) begin
        errors++;
        $display("FAIL arb_order[%0d]: got %0d expected %0d", i, grants[i], exp_seq[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hw_write(12'h010, 16'h1234, 3'd1);
    test_read(12'h010);
    test_hw_write(12'hF1F, 16'hBEEF, 3'd2);
    test_read(12'hF1F);
    test_host_fence();
    test_read(12'h020);
    test_out_of_range();
    test_read(12'hF20);
    test_reset_mid_read();
    test_arbitration();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
